// File: rtl/jtpopeye_objdma.sv
// jtpopeye_objdma: on each VB rise, copies ENTRIES x BYTES bytes from main RAM over the Z80 bus
// into the fill half of a double-buffered object table; the halves swap after a clean transfer.
module jtpopeye_objdma #(
    parameter int AW = 10,
    parameter int DW = 8,
    parameter int ENTRIES = 64,
    parameter int BYTES = 4,
    parameter logic [AW-1:0] BASE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pxl_cen,
    input  logic                         VB,
    output logic                         busrq_n,
    input  logic                         busak_n,
    output logic                         dma_cs,
    output logic [AW-1:0]                AD_DMA,
    input  logic [DW-1:0]                DD_DMA,
    input  logic [$clog2(ENTRIES)-1:0]   rd_addr,
    output logic [BYTES*DW-1:0]          rd_data,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);
    localparam int N  = ENTRIES * BYTES;
    localparam int IW = $clog2(N);
    localparam int EW = $clog2(ENTRIES);
    typedef enum logic [2:0] {IDLE, REQ, XFER, DRAIN, RELEASE} state_t;
    state_t state, state_d;
    logic vb_last, rise, fall, last, pend, bank;
    logic start, issue, cap, back, abort, swap;
    logic [IW-1:0] idx, wr_idx;
    logic [EW-1:0] wr_ent;
    int wr_byt;
    logic [BYTES*DW-1:0] acc, word;
    logic [BYTES*DW-1:0] mem [2*ENTRIES];
    assign rise = VB & ~vb_last;
    assign fall = ~VB & vb_last;
    assign last = idx == IW'(N - 1);
    assign wr_ent = wr_idx[IW-1 -: EW];
    assign wr_byt = int'(wr_idx) % BYTES;
    assign busrq_n = ~(state inside {REQ, XFER, DRAIN});
    assign dma_cs = state == XFER;
    assign busy = state != IDLE;
    // idx is the next byte to issue; wr_idx is the byte whose data arrives on the following tick
    always_comb begin
        state_d = state;
        start = 1'b0;
        issue = 1'b0;
        cap = 1'b0;
        back = 1'b0;
        abort = 1'b0;
        swap = 1'b0;
        if (pxl_cen)
            case (state)
                IDLE: state_d = rise ? REQ : IDLE;
                REQ: begin
                    start = ~busak_n;
                    state_d = busak_n ? REQ : XFER;
                end
                XFER: begin
                    issue = ~busak_n;
                    cap = ~busak_n & pend;
                    back = busak_n & pend;
                    state_d = (~busak_n & last) ? DRAIN : XFER;
                end
                DRAIN: begin
                    cap = ~busak_n;
                    back = busak_n;
                    state_d = busak_n ? XFER : RELEASE;
                end
                default: begin
                    swap = 1'b1;
                    state_d = IDLE;
                end
            endcase
        if (pxl_cen && fall && state inside {REQ, XFER, DRAIN}) begin
            start = 1'b0;
            issue = 1'b0;
            cap = 1'b0;
            back = 1'b0;
            abort = 1'b1;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            vb_last <= 1'b0;
            pend <= 1'b0;
            idx <= '0;
            wr_idx <= '0;
            AD_DMA <= '0;
            bank <= 1'b0;
            done <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state <= state_d;
            done <= swap;
            if (pxl_cen) vb_last <= VB;
            if (start) begin
                idx <= '0;
                AD_DMA <= BASE;
            end
            if (issue) begin
                wr_idx <= idx;
                if (!last) begin
                    idx <= idx + IW'(1);
                    AD_DMA <= AD_DMA + AW'(1);
                end
            end
            // a grant lost with a byte in flight rewinds to that byte so it is fetched again
            if (back) begin
                idx <= wr_idx;
                AD_DMA <= BASE + AW'(wr_idx);
            end
            if (start | cap | back | abort) pend <= 1'b0;
            if (issue) pend <= 1'b1;
            if (abort) overrun <= 1'b1;
            if (swap) begin
                bank <= ~bank;
                overrun <= 1'b0;
            end
        end
    end
    always_comb begin
        word = acc;
        word[wr_byt*DW +: DW] = DD_DMA;
    end
    always_ff @(posedge clk) begin
        if (cap) begin
            acc <= word;
            if (wr_byt == BYTES - 1) mem[{~bank, wr_ent}] <= word;
        end
        rd_data <= mem[{bank, rd_addr}];
    end
endmodule

// File: tb/tb_jtpopeye_objdma.sv
// tb_jtpopeye_objdma: randomized frame-level checks of the object DMA against a table model
// built from main-RAM contents, for the default build and two small parameter sets.
module tb_jtpopeye_objdma;
    logic clk = 1'b0, rst = 1'b1, pxl_cen = 1'b0;
    logic vb0 = 1'b0, busak0 = 1'b1, vb2 = 1'b0;
    logic busrq0, dma_cs0, busy0, done0, overrun0;
    logic busrq1, dma_cs1, busy1, done1, overrun1;
    logic busrq2, dma_cs2, busy2, done2, overrun2;
    logic [9:0] ad0, ad1, ad2;
    logic [7:0] dd0, dd1, dd2;
    logic [5:0] rd_addr0 = '0;
    logic [1:0] rd_addr1 = '0;
    logic [0:0] rd_addr2 = '0;
    logic [31:0] rd_data0, rd_data1;
    logic [7:0] rd_data2;
    logic [7:0] ram [1024];
    logic [31:0] shown0 [64];
    logic [31:0] fr0 [64];
    logic [7:0] shown2 [2];
    logic [7:0] nxt2 [2];
    logic [9:0] adq1 [$];
    int checks = 0, failures = 0, done_cnt0 = 0;

    jtpopeye_objdma u0 (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .VB(vb0), .busrq_n(busrq0), .busak_n(busak0),
        .dma_cs(dma_cs0), .AD_DMA(ad0), .DD_DMA(dd0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .busy(busy0), .done(done0), .overrun(overrun0)
    );
    jtpopeye_objdma #(.BASE(10'h3F8), .ENTRIES(4), .BYTES(4)) u1 (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .VB(vb2), .busrq_n(busrq1), .busak_n(busrq1),
        .dma_cs(dma_cs1), .AD_DMA(ad1), .DD_DMA(dd1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .busy(busy1), .done(done1), .overrun(overrun1)
    );
    jtpopeye_objdma #(.ENTRIES(2), .BYTES(1)) u2 (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .VB(vb2), .busrq_n(busrq2), .busak_n(busrq2),
        .dma_cs(dma_cs2), .AD_DMA(ad2), .DD_DMA(dd2), .rd_addr(rd_addr2), .rd_data(rd_data2),
        .busy(busy2), .done(done2), .overrun(overrun2)
    );

    // pxl_cen changes just after each rising edge, so it is high on every other edge
    initial forever begin
        #5 clk = 1'b1;
        #1 pxl_cen = ~pxl_cen;
        #4 clk = 1'b0;
    end

    always @(posedge clk) if (pxl_cen) begin
        dd0 <= ram[ad0];
        dd1 <= ram[ad1];
        dd2 <= ram[ad2];
    end

    always @(negedge clk) begin
        if (done0) done_cnt0++;
        if (pxl_cen && dma_cs1) adq1.push_back(ad1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        do @(posedge clk); while (!pxl_cen);
        @(negedge clk);
    endtask

    task automatic load_ram(input bit pattern);
        for (int i = 0; i < 1024; i++) ram[i] = pattern ? 8'(i) : 8'($urandom);
    endtask

    function automatic logic [31:0] entry(input int base, input int bytes, input int e);
        entry = '0;
        for (int b = 0; b < bytes; b++) entry[b*8 +: 8] = ram[10'(base + e * bytes + b)];
    endfunction

    task automatic check_rd0(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr0 = (i == 0) ? 6'd3 : 6'($urandom);
            @(negedge clk);
            check(tag, rd_data0, shown0[rd_addr0]);
        end
    endtask

    // one VB frame on u0; stall_ad/abort_ad/rst_ad < 0 disable that event
    task automatic frame0(input bit pattern, input int lat, input int stall_ad, input int stall_len,
                          input int abort_ad, input int rst_ad);
        int n, d0, extra, sl;
        bit ended;
        tick();
        load_ram(pattern);
        for (int e = 0; e < 64; e++) fr0[e] = entry(0, 4, e);
        d0 = done_cnt0;
        sl = (stall_ad >= 0) ? stall_len : 0;
        extra = (sl > 0) ? sl + 1 : 0;
        vb0 = 1'b1;
        n = 0;
        while (busrq0 && n < 8) begin
            tick();
            n++;
        end
        check("req", busrq0, 1'b0);
        repeat (lat) tick();
        busak0 = 1'b0;
        tick();
        n = 0;
        ended = 1'b0;
        while (!ended && !(busy0 && busrq0) && n < 400) begin
            if (sl > 0 && ad0 == 10'(stall_ad + 1)) begin
                busak0 = 1'b1;
                repeat (sl) begin
                    tick();
                    n++;
                    check("stall_hold", ad0, 10'(stall_ad));
                end
                busak0 = 1'b0;
                sl = 0;
            end else if (abort_ad >= 0 && ad0 == 10'(abort_ad)) begin
                vb0 = 1'b0;
                tick();
                check("abort_busrq", busrq0, 1'b1);
                check("abort_busy", busy0, 1'b0);
                check("abort_overrun", overrun0, 1'b1);
                ended = 1'b1;
            end else if (rst_ad >= 0 && ad0 == 10'(rst_ad)) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_busrq", busrq0, 1'b1);
                check("rst_cs", dma_cs0, 1'b0);
                check("rst_busy", busy0, 1'b0);
                check("rst_done", done0, 1'b0);
                rst = 1'b0;
                vb0 = 1'b0;
                ended = 1'b1;
            end else begin
                tick();
                n++;
            end
        end
        busak0 = 1'b1;
        if (!ended) begin
            check("len", n, 257 + extra);
            tick();
            vb0 = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check("done_pulse", done_cnt0 - d0, 1);
            check("overrun_clr", overrun0, 1'b0);
            check("idle", busy0, 1'b0);
            for (int e = 0; e < 64; e++) shown0[e] = fr0[e];
            check_rd0("table", 4);
        end else begin
            repeat (3) tick();
            check("no_done", done_cnt0 - d0, 0);
            check_rd0("kept", 3);
        end
    endtask

    initial begin
        int n;
        load_ram(1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        check("init_busrq", busrq0, 1'b1);
        check("init_cs", dma_cs0, 1'b0);
        check("init_ad", ad0, 10'd0);
        check("init_busy", busy0, 1'b0);
        check("init_done", done0, 1'b0);
        check("init_overrun", overrun0, 1'b0);
        frame0(1'b1, 2, -1, 0, -1, -1);
        frame0(1'b1, 2, 30, 10, -1, -1);
        frame0(1'b0, 1, -1, 0, -1, 20);
        frame0(1'b0, 2, -1, 0, 80, -1);
        frame0(1'b0, 3, -1, 0, -1, -1);
        repeat (2) frame0(1'b0, $urandom_range(0, 4), $urandom_range(0, 200), $urandom_range(1, 6), -1, -1);
        // u1 wraps AD_DMA past the top of the address space; u2 runs its first frame alongside
        load_ram(1'b0);
        vb2 = 1'b1;
        n = 0;
        while (!done1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("u1_done", done1, 1'b1);
        vb2 = 1'b0;
        repeat (4) tick();
        check("u1_count", adq1.size(), 16);
        for (int i = 0; i < 16; i++) begin
            check("u1_ad", adq1.size() > 0 ? adq1.pop_front() : 10'bx, 10'(10'h3F8 + i));
        end
        for (int e = 0; e < 4; e++) begin
            rd_addr1 = 2'(e);
            @(negedge clk);
            check("u1_entry", rd_data1, entry(10'h3F8, 4, e));
        end
        for (int e = 0; e < 2; e++) shown2[e] = ram[e];
        for (int k = 0; k < 4; k++) begin
            load_ram(1'b0);
            for (int e = 0; e < 2; e++) nxt2[e] = ram[e];
            rd_addr2 = 1'($urandom);
            vb2 = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
                check("u2_hold", rd_data2, shown2[rd_addr2]);
            end while (!done2 && n < 60);
            check("u2_done", done2, 1'b1);
            @(negedge clk);
            check("u2_new", rd_data2, nxt2[rd_addr2]);
            for (int e = 0; e < 2; e++) shown2[e] = nxt2[e];
            vb2 = 1'b0;
            tick();
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
